hold_err_scan_ctrl: RTL and testbench

HOLD_ERR_SCAN_CTRL -- requirements
Module: hold_err_scan_ctrl

---
 rtl/hold_err_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hold_err_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hold_err_scan_ctrl.sv
// hold_err_scan_ctrl: sequences clear / arm-window / scan / report over a bank
// of hold-error flop cells and keeps a saturating count of reported errors.
// Optional self-test (forces LA_Test on the cells) is built in only when
// HOLD_ERR_SELFTEST_EN is defined.
module hold_err_scan_ctrl #(
    parameter int unsigned N_CELLS = 8,
    parameter int unsigned WINDOW  = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       test_req,
    input  logic [N_CELLS-1:0]         err_in,
    input  logic                       report_ready,
    output logic                       cell_reset,
    output logic                       la_test,
    output logic                       err_valid,
    output logic [$clog2(N_CELLS)-1:0] err_idx,
    output logic [CNT_W-1:0]           err_count,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned              IDX_W    = $clog2(N_CELLS);
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(N_CELLS - 1);
    localparam logic [15:0]              WIN_LAST = 16'(WINDOW - 1);
    localparam logic [CNT_W-1:0]         CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARM,
        SCAN,
        REPORT,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cell_reset_q, cell_reset_d;

`ifdef HOLD_ERR_SELFTEST_EN
    logic               test_q, test_d;
`else
    logic               unused_test_req;
    assign unused_test_req = test_req;
`endif

    // State register and datapath flops; cell_reset is held high through reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            tmr_q        <= '0;
            cnt_q        <= '0;
            cell_reset_q <= 1'b1;
`ifdef HOLD_ERR_SELFTEST_EN
            test_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tmr_q        <= tmr_d;
            cnt_q        <= cnt_d;
            cell_reset_q <= cell_reset_d;
`ifdef HOLD_ERR_SELFTEST_EN
            test_q       <= test_d;
`endif
        end
    end

    // Next-state, scan index, phase timer and error counter
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
`ifdef HOLD_ERR_SELFTEST_EN
        test_d  = test_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    tmr_d   = '0;
                    idx_d   = '0;
`ifdef HOLD_ERR_SELFTEST_EN
                    test_d  = test_req;
`endif
                end
            end
            CLEAR: begin
                if (tmr_q == 16'd1) begin
                    state_d = ARM;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            ARM: begin
                if (tmr_q == WIN_LAST) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            SCAN: begin
                if (err_in[idx_q]) begin
                    state_d = REPORT;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            REPORT: begin
                if (report_ready) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
`ifdef HOLD_ERR_SELFTEST_EN
                test_d  = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cell_reset_d = (state_d == CLEAR);
    end

    // Output decode from the registered state
    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        err_valid  = (state_q == REPORT);
        err_idx    = idx_q;
        err_count  = cnt_q;
        cell_reset = cell_reset_q;
`ifdef HOLD_ERR_SELFTEST_EN
        la_test    = test_q && ((state_q == ARM) || (state_q == SCAN) || (state_q == REPORT));
`else
        la_test    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_hold_err_scan_ctrl.sv
// Directed bench for hold_err_scan_ctrl: main instance (8 cells, window 16,
// 16-bit count) plus a narrow-counter instance to exercise saturation.
module tb_hold_err_scan_ctrl;

`ifdef HOLD_ERR_SELFTEST_EN
    localparam bit ST = 1'b1;
`else
    localparam bit ST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       test_req = 1'b0;
    logic [7:0] err_pat = 8'h00;
    logic [7:0] err_in;
    logic       report_ready = 1'b0;
    logic       cell_reset, la_test, err_valid, busy, done;
    logic [2:0] err_idx;
    logic [15:0] err_count;

    logic       start_b = 1'b0;
    logic       cell_reset_b, la_test_b, err_valid_b, busy_b, done_b;
    logic [2:0] err_idx_b;
    logic [1:0] err_count_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Cell model: LA_Test forces every cell to flag an error
    assign err_in = err_pat | {8{la_test}};

    hold_err_scan_ctrl #(.N_CELLS(8), .WINDOW(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .test_req(test_req),
        .err_in(err_in), .report_ready(report_ready),
        .cell_reset(cell_reset), .la_test(la_test), .err_valid(err_valid),
        .err_idx(err_idx), .err_count(err_count), .busy(busy), .done(done)
    );

    hold_err_scan_ctrl #(.N_CELLS(8), .WINDOW(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .test_req(1'b0),
        .err_in(8'hFF), .report_ready(1'b1),
        .cell_reset(cell_reset_b), .la_test(la_test_b), .err_valid(err_valid_b),
        .err_idx(err_idx_b), .err_count(err_count_b), .busy(busy_b), .done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cyc;
        int done_cyc;
        int nvalid;
        int ndone;
        int nrep;
        logic [2:0] idx0, idx1;

        // Reset and idle
        #1 reset = 1'b0;
        #2;
        chk("rst_cell_reset", cell_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", err_valid, 0);
        chk("rst_count", err_count, 0);
        chk("rst_la_test", la_test, 0);
        tick(); tick();
        chk("rst_hold_cell_reset", cell_reset, 1);
        reset = 1'b1;
        #1;
        chk("rel_cell_reset_before_edge", cell_reset, 1);
        tick();
        chk("rel_cell_reset_after_edge", cell_reset, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("idle_busy", busy, 0);
        chk("idle_cell_reset", cell_reset, 0);
        chk("idle_done", done, 0);
        chk("idle_valid", err_valid, 0);
        chk("idle_count", err_count, 0);
        chk("idle_la_test", la_test, 0);

        // Clean scan: timing of clear window and done pulse
        err_pat = 8'h00;
        report_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        chk("clean_c1_cell_reset", cell_reset, 1);
        chk("clean_c1_busy", busy, 1);
        tick(); cyc++;
        chk("clean_c2_cell_reset", cell_reset, 1);
        tick(); cyc++;
        chk("clean_c3_cell_reset", cell_reset, 0);
        chk("clean_c3_busy", busy, 1);
        done_cyc = 0;
        for (int i = 0; i < 60 && done_cyc == 0; i++) begin
            tick(); cyc++;
            if (done) done_cyc = cyc;
        end
        chk("clean_done_cycle", done_cyc, 27);
        chk("clean_count", err_count, 0);
        tick();
        chk("clean_done_drop", done, 0);
        chk("clean_idle_busy", busy, 0);

        // Two errors, downstream always ready
        err_pat = 8'b1000_0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        nvalid = 0; ndone = 0; idx0 = '0; idx1 = '0;
        for (int i = 0; i < 40; i++) begin
            if (err_valid) begin
                if (nvalid == 0) idx0 = err_idx;
                if (nvalid == 1) idx1 = err_idx;
                nvalid++;
            end
            if (done) ndone++;
            tick();
        end
        chk("two_nvalid", nvalid, 2);
        chk("two_idx_first", idx0, 2);
        chk("two_idx_second", idx1, 7);
        chk("two_ndone", ndone, 1);
        chk("two_count", err_count, 2);
        chk("two_idle", busy, 0);

        // Backpressure: report held while ready low, err_in changes ignored
        err_pat = 8'h01;
        report_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !err_valid; i++) tick();
        chk("bp_valid_seen", err_valid, 1);
        err_pat = 8'h00;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", err_valid, 1);
            chk("bp_hold_idx", err_idx, 0);
            chk("bp_hold_count", err_count, 2);
            tick();
        end
        start = 1'b0;
        report_ready = 1'b1;
        tick();
        chk("bp_ack_valid", err_valid, 0);
        chk("bp_ack_count", err_count, 3);
        for (int i = 0; i < 40 && !done; i++) tick();
        chk("bp_done", done, 1);
        tick();
        chk("bp_idle", busy, 0);
        chk("bp_count_final", err_count, 3);

        // Self-test request
        err_pat = 8'h00;
        start = 1'b1;
        test_req = 1'b1;
        tick();
        start = 1'b0;
        test_req = 1'b0;
        chk("st_clear_la_test", la_test, 0);
        tick(); tick();
        chk("st_arm_la_test", la_test, ST);
        nrep = 0;
        done_cyc = 0;
        for (int i = 0; i < 60 && done_cyc == 0; i++) begin
            tick();
            if (err_valid) nrep++;
            if (done) begin
                done_cyc = 1;
                chk("st_done_la_test", la_test, 0);
            end
        end
        chk("st_done_seen", done_cyc, 1);
        chk("st_reports", nrep, ST ? 8 : 0);
        chk("st_count", err_count, ST ? 11 : 3);
        tick();
        chk("st_idle_la_test", la_test, 0);

        // Narrow counter saturates across scans
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 40 && !err_valid_b; i++) tick();
        chk("sat_first_idx", err_idx_b, 0);
        tick();
        chk("sat_after_first", err_count_b, 1);
        for (int i = 0; i < 80 && !done_b; i++) tick();
        chk("sat_scan1_done", done_b, 1);
        chk("sat_scan1_count", err_count_b, 3);
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 80 && !done_b; i++) tick();
        chk("sat_scan2_done", done_b, 1);
        chk("sat_scan2_count", err_count_b, 3);
        tick();

        // Reset during a pending report
        err_pat = 8'h01;
        report_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !err_valid; i++) tick();
        chk("mid_valid_seen", err_valid, 1);
        reset = 1'b0;
        #2;
        chk("mid_rst_valid", err_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cell_reset", cell_reset, 1);
        chk("mid_rst_count", err_count, 0);
        report_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("mid_rel_cell_reset", cell_reset, 0);
        chk("mid_rel_busy", busy, 0);
        chk("mid_rel_count", err_count, 0);
        chk("mid_rel_valid", err_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
